// File: rtl/controle_ula_if.sv
// Instruction issue channel between an instruction producer and controle_ula.
//
// Handshake: the producer raises inst_valido and holds every inst_* field
// stable until the controller accepts the instruction, which happens on the
// rising clock edge where inst_valido and inst_pronto are both high. The
// controller raises inst_pronto only while it is idle.
//
// Signals:
//   inst_valido    producer -> controller  instruction offered
//   inst_pronto    controller -> producer  controller can accept
//   inst_op[5:0]   bits [4:0] ALU selector, bit 5 suppresses register write
//   inst_ra/rb/rd  source A, source B, destination register indices
//   inst_usa_imed  operand e1 comes from inst_imediato instead of rb
//   inst_imediato  32-bit immediate operand
interface controle_ula_if;
  logic        inst_valido;
  logic        inst_pronto;
  logic [5:0]  inst_op;
  logic [4:0]  inst_ra;
  logic [4:0]  inst_rb;
  logic [4:0]  inst_rd;
  logic        inst_usa_imed;
  logic [31:0] inst_imediato;

  modport master (
    output inst_valido, inst_op, inst_ra, inst_rb, inst_rd,
           inst_usa_imed, inst_imediato,
    input  inst_pronto
  );

  modport slave (
    input  inst_valido, inst_op, inst_ra, inst_rb, inst_rd,
           inst_usa_imed, inst_imediato,
    output inst_pronto
  );
endinterface

// File: rtl/controle_ula.sv
// Multi-cycle issue controller in front of the 32-bit ALU.
//
// Accepts one instruction at a time on the inst channel, reads both operands
// from a synchronous-read register file, presents registered operands and the
// selector to the ALU for the operation's latency, then retires: s0 goes back
// to the register file, s1 to HI for MULT/DIVI, c0 to the flag for compares.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-low reset
//   inst                instruction channel (slave side)
//   rf_end0/rf_end1     register-file read addresses (data valid next cycle)
//   rf_dado0/rf_dado1   register-file read data
//   rf_escreve/rf_endw/rf_dadow  register-file write port (ESCRITA only)
//   ula_e0/ula_e1/ula_seletor    registered ALU operands and selector
//   ula_s0/ula_s1/ula_c0         ALU results
//   hi, flag, erro_div  HI register, compare flag, sticky divide-by-zero
//   res_valido          one-cycle pulse while an instruction retires
//   estado_dbg          current FSM state (OCIOSO=0 .. ESCRITA=3)
module controle_ula #(
  parameter int unsigned CICLOS_MULT = 2,
  parameter int unsigned CICLOS_DIV  = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  controle_ula_if.slave        inst,
  output logic [4:0]           rf_end0,
  output logic [4:0]           rf_end1,
  input  logic [31:0]          rf_dado0,
  input  logic [31:0]          rf_dado1,
  output logic                 rf_escreve,
  output logic [4:0]           rf_endw,
  output logic [31:0]          rf_dadow,
  output logic [31:0]          ula_e0,
  output logic [31:0]          ula_e1,
  output logic [5:0]           ula_seletor,
  input  logic [31:0]          ula_s0,
  input  logic [31:0]          ula_s1,
  input  logic                 ula_c0,
  output logic [31:0]          hi,
  output logic                 flag,
  output logic                 erro_div,
  output logic                 res_valido,
  output logic [1:0]           estado_dbg
);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    LEITURA = 2'd1,
    EXECUTA = 2'd2,
    ESCRITA = 2'd3
  } estado_t;

  localparam logic [4:0]  OP_MULT  = 5'b00010;
  localparam logic [4:0]  OP_DIVI  = 5'b00011;
  localparam logic [15:0] CONT_MULT = 16'(CICLOS_MULT);
  localparam logic [15:0] CONT_DIV  = 16'(CICLOS_DIV);

  estado_t     estado, prox;
  logic [15:0] cont;
  logic [5:0]  op_q;
  logic [4:0]  rd_q;
  logic        usa_imed_q;
  logic [31:0] imed_q;

  logic        aceita;
  logic        em_escrita;
  logic        div_zero;
  logic        op_flag;

  assign estado_dbg = estado;

  // Divide by zero is judged on the operand actually presented to the ALU.
  assign div_zero = (op_q[4:0] == OP_DIVI) && (ula_e1 == 32'd0);
  assign op_flag  = op_q[4:0] inside {5'b01010, 5'b01011, 5'b01100, 5'b01111};

  // Next state and all combinational outputs.
  always_comb begin
    prox             = estado;
    inst.inst_pronto = 1'b0;
    aceita           = 1'b0;
    em_escrita       = 1'b0;
    rf_end0          = 5'd0;
    rf_end1          = 5'd0;
    rf_escreve       = 1'b0;
    rf_endw          = 5'd0;
    rf_dadow         = 32'd0;
    res_valido       = 1'b0;

    case (estado)
      OCIOSO: begin
        inst.inst_pronto = 1'b1;
        aceita           = inst.inst_valido;
        // Addresses go out during the accept cycle so the synchronous RF
        // has the data ready throughout LEITURA.
        if (inst.inst_valido) begin
          rf_end0 = inst.inst_ra;
          rf_end1 = inst.inst_rb;
        end
        if (aceita) prox = LEITURA;
      end
      LEITURA: prox = EXECUTA;
      EXECUTA: begin
        // <= 1 rather than == 1 so a zero count can never stall the FSM.
        if (cont <= 16'd1) prox = ESCRITA;
      end
      ESCRITA: begin
        em_escrita = 1'b1;
        res_valido = 1'b1;
        rf_endw    = rd_q;
        rf_dadow   = div_zero ? 32'hFFFF_FFFF : ula_s0;
        rf_escreve = !op_q[5] && (rd_q != 5'd0);
        prox       = OCIOSO;
      end
      default: prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado      <= OCIOSO;
      cont        <= 16'd0;
      op_q        <= 6'd0;
      rd_q        <= 5'd0;
      usa_imed_q  <= 1'b0;
      imed_q      <= 32'd0;
      ula_e0      <= 32'd0;
      ula_e1      <= 32'd0;
      ula_seletor <= 6'd0;
      hi          <= 32'd0;
      flag        <= 1'b0;
      erro_div    <= 1'b0;
    end else begin
      estado <= prox;
      case (estado)
        OCIOSO: begin
          if (aceita) begin
            op_q       <= inst.inst_op;
            rd_q       <= inst.inst_rd;
            usa_imed_q <= inst.inst_usa_imed;
            imed_q     <= inst.inst_imediato;
          end
        end
        LEITURA: begin
          ula_e0      <= rf_dado0;
          ula_e1      <= usa_imed_q ? imed_q : rf_dado1;
          ula_seletor <= op_q;
          if (op_q[4:0] == OP_MULT)      cont <= CONT_MULT;
          else if (op_q[4:0] == OP_DIVI) cont <= CONT_DIV;
          else                           cont <= 16'd1;
        end
        EXECUTA: begin
          if (cont > 16'd1) cont <= cont - 16'd1;
        end
        ESCRITA: begin
          if (em_escrita) begin
            if (div_zero) begin
              hi       <= ula_e0;
              erro_div <= 1'b1;
            end else if (op_q[4:1] == 4'b0001) begin
              hi <= ula_s1;
            end
            if (op_flag) flag <= ula_c0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controle_ula.sv
module tb_controle_ula;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  controle_ula_if bus ();

  logic [4:0]  rf_end0, rf_end1, rf_endw;
  logic [31:0] rf_dado0, rf_dado1, rf_dadow;
  logic        rf_escreve;
  logic [31:0] ula_e0, ula_e1, ula_s0, ula_s1;
  logic [5:0]  ula_seletor;
  logic        ula_c0;
  logic [31:0] hi;
  logic        flag, erro_div, res_valido;
  logic [1:0]  estado_dbg;

  controle_ula #(.CICLOS_MULT(2), .CICLOS_DIV(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .inst        (bus),
    .rf_end0     (rf_end0),
    .rf_end1     (rf_end1),
    .rf_dado0    (rf_dado0),
    .rf_dado1    (rf_dado1),
    .rf_escreve  (rf_escreve),
    .rf_endw     (rf_endw),
    .rf_dadow    (rf_dadow),
    .ula_e0      (ula_e0),
    .ula_e1      (ula_e1),
    .ula_seletor (ula_seletor),
    .ula_s0      (ula_s0),
    .ula_s1      (ula_s1),
    .ula_c0      (ula_c0),
    .hi          (hi),
    .flag        (flag),
    .erro_div    (erro_div),
    .res_valido  (res_valido),
    .estado_dbg  (estado_dbg)
  );

  // ---------------- register file model ----------------
  logic [31:0] regs [32];
  logic        pre_we;
  logic [4:0]  pre_a;
  logic [31:0] pre_d;

  initial for (int i = 0; i < 32; i++) regs[i] = 32'd0;

  always @(posedge clock) begin
    rf_dado0 <= regs[rf_end0];
    rf_dado1 <= regs[rf_end1];
    if (pre_we) regs[pre_a] <= pre_d;
    else if (rf_escreve && rf_endw != 5'd0) regs[rf_endw] <= rf_dadow;
  end

  // ---------------- ALU model ----------------
  logic [63:0] prod;
  always_comb begin
    ula_s0 = 32'd0;
    ula_s1 = 32'd0;
    ula_c0 = 1'b0;
    prod   = 64'(ula_e0) * 64'(ula_e1);
    case (ula_seletor[4:0])
      5'b00000: ula_s0 = ula_e0 + ula_e1;
      5'b00010: {ula_s1, ula_s0} = prod;
      5'b00011: begin
        if (ula_e1 != 32'd0) begin
          ula_s0 = ula_e0 / ula_e1;
          ula_s1 = ula_e0 % ula_e1;
        end else begin
          ula_s0 = 32'h0000_1234;
          ula_s1 = 32'h0000_5678;
        end
      end
      5'b01010: ula_c0 = $signed(ula_e0) < $signed(ula_e1);
      5'b01011: ula_c0 = ula_e0 < ula_e1;
      5'b01100: ula_c0 = ula_e0 == ula_e1;
      5'b01111: ula_c0 = ula_e0 != ula_e1;
      5'b10000: ula_s0 = ula_e0;
      default:  ula_s0 = ula_e0 ^ ula_e1;
    endcase
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act);
    logic [31:0] e;
    e = exp_q.pop_front();
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  int          lat;
  logic        got_esc;
  logic [4:0]  got_endw;
  logic [31:0] got_dadow;
  logic [5:0]  got_sel;

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    @(negedge clock);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    @(negedge clock);
    pre_we = 1'b0;
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] ra, rb, rd,
                       input logic usa, input logic [31:0] imm);
    bus.inst_op = op; bus.inst_ra = ra; bus.inst_rb = rb; bus.inst_rd = rd;
    bus.inst_usa_imed = usa; bus.inst_imediato = imm;
    bus.inst_valido = 1'b1;
  endtask

  // Issue one instruction and follow it to retirement; lat counts edges from
  // the accept edge to the edge that ends ESCRITA.
  task automatic issue(input logic [5:0] op, input logic [4:0] ra, rb, rd,
                       input logic usa, input logic [31:0] imm);
    int w;
    @(negedge clock);
    drive(op, ra, rb, rd, usa, imm);
    w = 0;
    while (!bus.inst_pronto && w < 20) begin @(negedge clock); w++; end
    if (!bus.inst_pronto) begin
      errors++; checks++;
      $display("FAIL accept_timeout: got pronto=0 expected pronto=1");
    end
    @(posedge clock);
    @(negedge clock);
    bus.inst_valido = 1'b0;
    lat = 1;
    while (!res_valido && lat < 30) begin @(negedge clock); lat++; end
    got_esc = rf_escreve; got_endw = rf_endw; got_dadow = rf_dadow;
    got_sel = ula_seletor;
    if (!res_valido) begin
      errors++; checks++;
      $display("FAIL retire_timeout: got res_valido=0 expected 1");
    end
    @(negedge clock);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [5:0]  op;
    logic [4:0]  ra, rb, rd;
    logic        usa;
    logic [31:0] imm;
    logic        pre;
    logic [31:0] va, vb;
    logic        e_esc;
    logic [31:0] e_dadow, e_hi;
    logic        e_flag, e_err;
    int          e_lat;
  } vec_t;

  vec_t vecs[13];

  logic will_acc;
  int   acc, ret, last_c, wr_seen;

  initial begin
    //          op        ra rb rd usa imm  pre va            vb            esc dadow          hi     fl er lat
    vecs[0]  = '{6'b000000, 1, 2, 3, 0, 0, 1, 32'd7,        32'd5,        1, 32'd12,        32'd0,  0, 0, 3};
    vecs[1]  = '{6'b000010, 1, 2, 4, 0, 0, 1, 32'h0001_0000, 32'h0001_0000, 1, 32'd0,       32'd1,  0, 0, 4};
    vecs[2]  = '{6'b000011, 1, 2, 5, 0, 0, 1, 32'd17,       32'd5,        1, 32'd3,         32'd2,  0, 0, 6};
    vecs[3]  = '{6'b000011, 1, 2, 5, 0, 0, 1, 32'd17,       32'd0,        1, 32'hFFFF_FFFF, 32'd17, 0, 1, 6};
    vecs[4]  = '{6'b101010, 1, 2, 3, 1, 9, 1, 32'd3,        32'd0,        0, 32'd0,         32'd17, 1, 1, 3};
    vecs[5]  = '{6'b101100, 1, 2, 3, 1, 3, 1, 32'd3,        32'd0,        0, 32'd0,         32'd17, 1, 1, 3};
    vecs[6]  = '{6'b000000, 1, 2, 0, 0, 0, 1, 32'd7,        32'd5,        0, 32'd12,        32'd17, 1, 1, 3};
    vecs[7]  = '{6'b101100, 1, 2, 3, 1, 4, 1, 32'd3,        32'd0,        0, 32'd0,         32'd17, 0, 1, 3};
    vecs[8]  = '{6'b010000, 1, 2, 6, 0, 0, 1, 32'h0000_ABCD, 32'd0,       1, 32'h0000_ABCD, 32'd17, 0, 1, 3};
    vecs[9]  = '{6'b000000, 6, 6, 7, 0, 0, 0, 32'd0,        32'd0,        1, 32'h0001_579A, 32'd17, 0, 1, 3};
    vecs[10] = '{6'b000010, 1, 2, 9, 0, 0, 1, 32'hFFFF_FFFF, 32'd2,       1, 32'hFFFF_FFFE, 32'd1,  0, 1, 4};
    vecs[11] = '{6'b101111, 1, 2, 3, 0, 0, 1, 32'd5,        32'd5,        0, 32'd0,         32'd1,  0, 1, 3};
    vecs[12] = '{6'b001011, 1, 2, 13, 1, 9, 1, 32'd3,       32'd0,        1, 32'd0,         32'd1,  1, 1, 3};

    // reset
    reset = 1'b0; pre_we = 1'b0; pre_a = 5'd0; pre_d = 32'd0;
    bus.inst_valido = 1'b0; drive(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
    bus.inst_valido = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    exp_q.push_back(32'd1); chk("rst_pronto", 32'(bus.inst_pronto));
    exp_q.push_back(32'd0); chk("rst_escreve", 32'(rf_escreve));
    exp_q.push_back(32'd0); chk("rst_res_valido", 32'(res_valido));
    exp_q.push_back(32'd0); chk("rst_rf_end0", 32'(rf_end0));
    exp_q.push_back(32'd0); chk("rst_ula_e0", ula_e0);
    exp_q.push_back(32'd0); chk("rst_ula_sel", 32'(ula_seletor));
    exp_q.push_back(32'd0); chk("rst_hi", hi);
    exp_q.push_back(32'd0); chk("rst_flag_err", {30'd0, flag, erro_div});

    // table-driven vectors
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].pre) begin
        preload(vecs[i].ra, vecs[i].va);
        preload(vecs[i].rb, vecs[i].vb);
      end
      issue(vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].rd, vecs[i].usa, vecs[i].imm);
      exp_q.push_back(32'(vecs[i].e_lat));   chk($sformatf("v%0d_lat", i), 32'(lat));
      exp_q.push_back(32'(vecs[i].e_esc));   chk($sformatf("v%0d_escreve", i), 32'(got_esc));
      exp_q.push_back(32'(vecs[i].rd));      chk($sformatf("v%0d_endw", i), 32'(got_endw));
      exp_q.push_back(vecs[i].e_dadow);      chk($sformatf("v%0d_dadow", i), got_dadow);
      exp_q.push_back(32'(vecs[i].op));      chk($sformatf("v%0d_seletor", i), 32'(got_sel));
      exp_q.push_back(vecs[i].e_hi);         chk($sformatf("v%0d_hi", i), hi);
      exp_q.push_back(32'(vecs[i].e_flag));  chk($sformatf("v%0d_flag", i), 32'(flag));
      exp_q.push_back(32'(vecs[i].e_err));   chk($sformatf("v%0d_erro_div", i), 32'(erro_div));
      exp_q.push_back(32'd1);                chk($sformatf("v%0d_pronto_after", i), 32'(bus.inst_pronto));
    end

    // back-to-back issue with inst_valido held high
    preload(5'd1, 32'd7);
    preload(5'd2, 32'd5);
    @(negedge clock);
    drive(6'b000000, 5'd1, 5'd2, 5'd20, 1'b0, 32'd0);
    acc = 0; ret = 0; last_c = 0;
    for (int c = 0; c < 20; c++) begin
      will_acc = bus.inst_pronto && bus.inst_valido;
      if (res_valido) ret++;
      @(posedge clock);
      if (will_acc) begin
        if (acc > 0) begin
          exp_q.push_back(32'd4); chk("b2b_interval", 32'(c - last_c));
        end
        last_c = c;
        acc++;
      end
      @(negedge clock);
      if (will_acc) begin
        if (acc == 3) bus.inst_valido = 1'b0;
        else bus.inst_rd = 5'(20 + acc);
      end
    end
    exp_q.push_back(32'd3);  chk("b2b_accepts", 32'(acc));
    exp_q.push_back(32'd3);  chk("b2b_retires", 32'(ret));
    exp_q.push_back(32'd12); chk("b2b_r20", regs[20]);
    exp_q.push_back(32'd12); chk("b2b_r21", regs[21]);
    exp_q.push_back(32'd12); chk("b2b_r22", regs[22]);

    // reset during a DIVI in EXECUTA aborts it
    preload(5'd1, 32'd17);
    preload(5'd2, 32'd5);
    @(negedge clock);
    drive(6'b000011, 5'd1, 5'd2, 5'd11, 1'b0, 32'd0);
    @(posedge clock);
    @(negedge clock);
    bus.inst_valido = 1'b0;
    wr_seen = 0;
    @(negedge clock);
    exp_q.push_back(32'd2); chk("abort_in_executa", 32'(estado_dbg));
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    exp_q.push_back(32'd0); chk("abort_hi", hi);
    exp_q.push_back(32'd0); chk("abort_flag", 32'(flag));
    exp_q.push_back(32'd0); chk("abort_erro_div", 32'(erro_div));
    exp_q.push_back(32'd1); chk("abort_pronto", 32'(bus.inst_pronto));
    for (int c = 0; c < 8; c++) begin
      if (rf_escreve || res_valido) wr_seen++;
      @(negedge clock);
    end
    exp_q.push_back(32'd0); chk("abort_no_write", 32'(wr_seen));
    exp_q.push_back(32'd0); chk("abort_r11", regs[11]);
    issue(6'b000000, 5'd1, 5'd2, 5'd12, 1'b0, 32'd0);
    exp_q.push_back(32'd3);  chk("after_abort_lat", 32'(lat));
    exp_q.push_back(32'd1);  chk("after_abort_escreve", 32'(got_esc));
    exp_q.push_back(32'd22); chk("after_abort_dadow", got_dadow);
    exp_q.push_back(32'd22); chk("after_abort_r12", regs[12]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
